// File: rtl/voter4_pkg.sv
// Shared types and constants for the 4-member voting session controller.
// Contents: state_t session state enum, voter count and tally width,
// and a popcount helper used to add several simultaneous yes votes.
package voter4_pkg;

    localparam int N_VOTERS = 4;
    localparam int CNT_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        TALLY = 2'd2,
        SHOW  = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] count_ones(input logic [N_VOTERS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/voter4_win_timer.sv
// Loadable down-counter with terminal-count flag, shared by the vote window
// and the result display period.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (count -> 0)
//   load      - load load_val this cycle (takes priority over counting)
//   load_val  - value to load; a period of N cycles is loaded as N-1
//   tc        - high while the count is zero
module voter4_win_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/voter4_session_ctrl.sv
// Voting session controller around a 4-input majority vote.
// A start edge opens a timed window; each member casts one yes/no vote;
// the window closes on timeout or once all four have voted; the result is
// shown on led for a display period, then the block returns to idle.
//
// Optional build macro: VOTER4_SESSION_TIE_EN adds the tie output and
// forces led low on a 2 yes / 2 no result.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - session request, acted on at its rising edge in IDLE
//   vote_req     - per-member cast strobe, acted on at rising edge in OPEN
//   vote_val     - per-member vote value (1 = yes), sampled with vote_req
//   busy         - session in progress (OPEN, TALLY, SHOW)
//   window_open  - vote window open
//   voted        - members that have cast in the current session
//   yes_cnt      - yes votes cast so far
//   led          - pass indicator, valid in SHOW
//   done         - one-cycle pulse in the first SHOW cycle
//   tie          - (macro only) 2/2 split, held through SHOW
//
// state | meaning
// IDLE  | waiting for start edge, led forced low
// OPEN  | vote window running, votes latched
// TALLY | one cycle, pass/tie decision registered
// SHOW  | result displayed for SHOW_CYCLES, results frozen
module voter4_session_ctrl
    import voter4_pkg::*;
#(
    parameter int WIN_CYCLES  = 12000000,
    parameter int SHOW_CYCLES = 24000000,
    parameter int PASS_TH     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_req,
    input  logic [N_VOTERS-1:0] vote_val,
    output logic                busy,
    output logic                window_open,
    output logic [N_VOTERS-1:0] voted,
    output logic [CNT_W-1:0]    yes_cnt,
    output logic                led,
    output logic                done
`ifdef VOTER4_SESSION_TIE_EN
    ,
    output logic                tie
`endif
);

    localparam int MAX_CYC = (WIN_CYCLES > SHOW_CYCLES) ? WIN_CYCLES : SHOW_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]    WIN_LOAD  = TW'(WIN_CYCLES - 1);
    localparam logic [TW-1:0]    SHOW_LOAD = TW'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] PASS_C    = CNT_W'(PASS_TH);

    state_t state, state_next;

    logic                start_prev;
    logic [N_VOTERS-1:0] req_prev;
    logic                start_edge;
    logic [N_VOTERS-1:0] new_cast;
    logic [CNT_W-1:0]    new_yes;

    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_tc;

    // History registers reset to 1 so a level already high at reset
    // release is not mistaken for an edge.
    assign start_edge = start & ~start_prev;
    assign new_cast   = vote_req & ~req_prev & ~voted;
    assign new_yes    = count_ones(new_cast & vote_val);

    assign busy        = (state != IDLE);
    assign window_open = (state == OPEN);

    voter4_win_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE:    if (start_edge) state_next = OPEN;
            // Early close looks at the registered voted vector, so the
            // window closes the cycle after the fourth vote lands.
            OPEN:    if (timer_tc || (voted == '1)) state_next = TALLY;
            TALLY:   state_next = SHOW;
            SHOW:    if (timer_tc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // The timer restarts on every state change; a period of N cycles
        // is loaded as N-1 so tc coincides with the last cycle.
        if (state_next != state) begin
            timer_load = 1'b1;
            if (state_next == OPEN) begin
                timer_val = WIN_LOAD;
            end else if (state_next == SHOW) begin
                timer_val = SHOW_LOAD;
            end
        end
    end

`ifdef VOTER4_SESSION_TIE_EN
    logic tie_now;
    // A tie needs every member to have voted: 2 yes against 2 no.
    assign tie_now = (voted == '1) && (yes_cnt == CNT_W'(N_VOTERS / 2));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev <= 1'b1;
            req_prev   <= '1;
            voted      <= '0;
            yes_cnt    <= '0;
            led        <= 1'b0;
            done       <= 1'b0;
`ifdef VOTER4_SESSION_TIE_EN
            tie        <= 1'b0;
`endif
        end else begin
            start_prev <= start;
            req_prev   <= vote_req;
            done       <= (state == TALLY);
            case (state)
                IDLE: begin
                    led <= 1'b0;
`ifdef VOTER4_SESSION_TIE_EN
                    tie <= 1'b0;
`endif
                    if (start_edge) begin
                        voted   <= '0;
                        yes_cnt <= '0;
                    end
                end
                OPEN: begin
                    voted   <= voted | new_cast;
                    yes_cnt <= yes_cnt + new_yes;
                end
                TALLY: begin
`ifdef VOTER4_SESSION_TIE_EN
                    tie <= tie_now;
                    led <= (yes_cnt >= PASS_C) && !tie_now;
`else
                    led <= (yes_cnt >= PASS_C);
`endif
                end
                SHOW: begin
                    if (timer_tc) begin
                        led <= 1'b0;
`ifdef VOTER4_SESSION_TIE_EN
                        tie <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voter4_session_ctrl.sv
module tb_voter4_session_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] vote_req;
    logic [3:0] vote_val;
    logic       busy;
    logic       window_open;
    logic [3:0] voted;
    logic [2:0] yes_cnt;
    logic       led;
    logic       done;
`ifdef VOTER4_SESSION_TIE_EN
    logic       tie;
`endif

    typedef struct {
        logic       led;
        logic [2:0] yes;
        logic [3:0] voted;
        logic       tie;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [3:0] req_tab [0:31];
    logic [3:0] val_tab [0:31];

    voter4_session_ctrl #(
        .WIN_CYCLES  (20),
        .SHOW_CYCLES (10),
        .PASS_TH     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .vote_req    (vote_req),
        .vote_val    (vote_val),
        .busy        (busy),
        .window_open (window_open),
        .voted       (voted),
        .yes_cnt     (yes_cnt),
        .led         (led),
        .done        (done)
`ifdef VOTER4_SESSION_TIE_EN
        ,
        .tie         (tie)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tab();
        for (int i = 0; i < 32; i++) begin
            req_tab[i] = 4'b0000;
            val_tab[i] = 4'b0000;
        end
    endtask

    task automatic push_exp(input logic l, input logic [2:0] y, input logic [3:0] v,
                            input logic t);
        exp_t e;
        e.led = l; e.yes = y; e.voted = v; e.tie = t;
        sb.push_back(e);
    endtask

    // Start a session and play req_tab/val_tab, indexed by OPEN cycle
    // number, until the window closes. len = number of OPEN cycles.
    task automatic run_session(input int chk_n, input logic [3:0] chk_voted,
                               input logic [2:0] chk_yes, output int len);
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("window_open_latency", int'(window_open), 1);
        n = 1;
        while (window_open && n < 100) begin
            if (n == chk_n) begin
                chk("mid_voted", int'(voted), int'(chk_voted));
                chk("mid_yes_cnt", int'(yes_cnt), int'(chk_yes));
            end
            vote_req = (n < 32) ? req_tab[n] : 4'b0000;
            vote_val = (n < 32) ? val_tab[n] : 4'b0000;
            tick();
            n++;
        end
        vote_req = 4'b0000;
        vote_val = 4'b0000;
        len = n - 1;
    endtask

    // From TALLY, run through SHOW back to IDLE; optionally pulse start
    // in tally/show cycle start_at. Returns cycles spent busy.
    task automatic finish_session(input int start_at, output int k);
        k = 0;
        while (busy && k < 100) begin
            start = (k == start_at);
            tick();
            k++;
        end
        start = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending at %0t",
                             $time);
                end else begin
                    e = sb.pop_front();
                    chk("sb_led", int'(led), int'(e.led));
                    chk("sb_yes_cnt", int'(yes_cnt), int'(e.yes));
                    chk("sb_voted", int'(voted), int'(e.voted));
`ifdef VOTER4_SESSION_TIE_EN
                    chk("sb_tie", int'(tie), int'(e.tie));
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int len;
        int k;
        rst      = 1'b1;
        start    = 1'b0;
        vote_req = 4'b0000;
        vote_val = 4'b0000;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_window_open", int'(window_open), 0);
        chk("rst_voted", int'(voted), 0);
        chk("rst_yes_cnt", int'(yes_cnt), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        tick();

        // Session 1: members 0,1,2 yes and 3 no at OPEN cycles 3..6.
        clear_tab();
        req_tab[3] = 4'b0001; val_tab[3] = 4'b0001;
        req_tab[4] = 4'b0010; val_tab[4] = 4'b0010;
        req_tab[5] = 4'b0100; val_tab[5] = 4'b0100;
        req_tab[6] = 4'b1000; val_tab[6] = 4'b0000;
        push_exp(1'b1, 3'd3, 4'b1111, 1'b0);
        run_session(5, 4'b0011, 3'd2, len);
        chk("s1_open_len", len, 7);
        finish_session(-1, k);
        chk("s1_busy_len", k, 11);
        chk("s1_idle_led", int'(led), 0);
        tick();

        // Session 2: members 0 and 1 yes, window times out.
        clear_tab();
        req_tab[2] = 4'b0001; val_tab[2] = 4'b0001;
        req_tab[4] = 4'b0010; val_tab[4] = 4'b0010;
        push_exp(1'b0, 3'd2, 4'b0011, 1'b0);
        run_session(0, 4'b0000, 3'd0, len);
        chk("s2_open_len", len, 20);
        finish_session(-1, k);
        chk("s2_busy_len", k, 11);

        // Vote edges in IDLE must not disturb the frozen counters.
        vote_req = 4'b1111; vote_val = 4'b1111;
        tick();
        vote_req = 4'b0000; vote_val = 4'b0000;
        tick();
        chk("idle_vote_voted", int'(voted), 4'b0011);
        chk("idle_vote_yes_cnt", int'(yes_cnt), 2);
        chk("idle_vote_busy", int'(busy), 0);

        // Session 3: member 2 presses yes three times then no; member 3
        // votes yes in the final window cycle.
        clear_tab();
        req_tab[2]  = 4'b0100; val_tab[2] = 4'b0100;
        req_tab[4]  = 4'b0100; val_tab[4] = 4'b0100;
        req_tab[6]  = 4'b0100; val_tab[6] = 4'b0100;
        req_tab[8]  = 4'b0100; val_tab[8] = 4'b0000;
        req_tab[20] = 4'b1000; val_tab[20] = 4'b1000;
        push_exp(1'b0, 3'd2, 4'b1100, 1'b0);
        run_session(10, 4'b0100, 3'd1, len);
        chk("s3_open_len", len, 20);
        finish_session(-1, k);
        chk("s3_busy_len", k, 11);

        // Session 4: all four cast together, start edge during SHOW.
        clear_tab();
        req_tab[2] = 4'b1111; val_tab[2] = 4'b1011;
        push_exp(1'b1, 3'd3, 4'b1111, 1'b0);
        run_session(3, 4'b1111, 3'd3, len);
        chk("s4_open_len", len, 3);
        finish_session(3, k);
        chk("s4_busy_len", k, 11);
        tick();
        chk("s4_no_restart_busy", int'(busy), 0);
        chk("s4_idle_led", int'(led), 0);

        // Session 5: reset mid-OPEN with two yes votes.
        start = 1'b1;
        tick();
        start = 1'b0;
        vote_req = 4'b0011; vote_val = 4'b0011;
        tick();
        vote_req = 4'b0000; vote_val = 4'b0000;
        tick();
        chk("s5_yes_before_rst", int'(yes_cnt), 2);
        rst = 1'b1;
        tick();
        chk("s5_rst_busy", int'(busy), 0);
        chk("s5_rst_window_open", int'(window_open), 0);
        chk("s5_rst_voted", int'(voted), 0);
        chk("s5_rst_yes_cnt", int'(yes_cnt), 0);
        chk("s5_rst_led", int'(led), 0);
        chk("s5_rst_done", int'(done), 0);
        rst = 1'b0;
        repeat (25) tick();
        chk("s5_still_idle", int'(busy), 0);

`ifdef VOTER4_SESSION_TIE_EN
        // Session 6: 2 yes / 2 no.
        clear_tab();
        req_tab[2] = 4'b1111; val_tab[2] = 4'b0011;
        push_exp(1'b0, 3'd2, 4'b1111, 1'b1);
        run_session(0, 4'b0000, 3'd0, len);
        chk("s6_open_len", len, 3);
        finish_session(-1, k);
        chk("s6_idle_tie", int'(tie), 0);
`endif

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
